// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the seven-segment scan controller.
//   SSEG_OFF / AN_OFF : all-dark values for the active-low segment and anode buses
//   seg_code()        : hex nibble -> active-low segment pattern (dp bit7 = off)
package sseg_pkg;

    localparam logic [7:0] SSEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF   = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex-to-seven-segment decoder.
//   nibble : hex digit value
//   dp     : decimal point request (1 = lit)
//   seg    : active-low segments, bit7 = dp, bits6..0 = g..a
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = seg_code(nibble);
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed seven-segment display scanner with double-buffered
// digit registers, PWM brightness and per-digit blink.
//   clk, clear_n        : clock, async active-low reset
//   load, load_*        : one-cycle capture of data/dp/blank/blink into the shadow set
//   brightness          : live PWM duty level
//   update_pending      : shadow holds values not yet moved to the active set
//   frame_strobe        : high on the last cycle of each frame
//   sseg, an            : registered active-low segment and anode drives
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 65536,
    parameter int PWM_BITS    = 3,
    parameter int BLINK_LOG2  = 6
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic [NUM_DIGITS-1:0]   load_blink,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    update_pending,
    output logic                    frame_strobe,
    output logic [7:0]              sseg,
    output logic [7:0]              an
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int FRAME_W = BLINK_LOG2 + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]        DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [2:0]              digit_idx;
    logic [FRAME_W-1:0]      frame_cnt;

    logic [4*NUM_DIGITS-1:0] sh_data,  act_data;
    logic [NUM_DIGITS-1:0]   sh_dp,    act_dp;
    logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
    logic [NUM_DIGITS-1:0]   sh_blink, act_blink;
    logic                    pending;

    logic                    slot_wrap;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    dark;
    logic                    pwm_on;
    logic [7:0]              dec_seg;
    logic [7:0]              seg_next;
    logic [7:0]              an_next;

    assign slot_wrap      = (slot_cnt == SLOT_LAST);
    assign boundary       = slot_wrap && (digit_idx == DIGIT_LAST);
    assign frame_strobe   = boundary;
    assign update_pending = pending;

    // Scan timing: slot counter wraps naturally (REFRESH_DIV is a power of two).
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= (digit_idx == DIGIT_LAST) ? 3'd0 : digit_idx + 3'd1;
            end
            if (boundary) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in the shadow set and move to the active set only
    // at a frame boundary, so a frame never shows a mix of old and new digits.
    // A load coinciding with the boundary bypasses the shadow stage.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_blink  <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                sh_data  <= load_data;
                sh_dp    <= load_dp;
                sh_blank <= load_blank;
                sh_blink <= load_blink;
            end
            if (load && boundary) begin
                act_data  <= load_data;
                act_dp    <= load_dp;
                act_blank <= load_blank;
                act_blink <= load_blink;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (boundary && pending) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                act_blink <= sh_blink;
                pending   <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_blink = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == 3'(i)) begin
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = act_blank[i];
                cur_blink = act_blink[i];
            end
        end
    end

    sseg_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    assign dark   = cur_blank | (cur_blink & frame_cnt[BLINK_LOG2]);
    assign pwm_on = (slot_cnt[SLOT_W-1 -: PWM_BITS] <= brightness);

    always_comb begin
        seg_next = SSEG_OFF;
        an_next  = AN_OFF;
        if (!dark) begin
            seg_next = dec_seg;
            if (pwm_on) begin
                an_next[digit_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sseg <= SSEG_OFF;
            an   <= AN_OFF;
        end else begin
            sseg <= seg_next;
            an   <= an_next;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic [3:0]  load_blank = '0;
    logic [3:0]  load_blink = '0;
    logic [1:0]  brightness = 2'd3;
    logic        update_pending;
    logic        frame_strobe;
    logic [7:0]  sseg;
    logic [7:0]  an;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (16),
        .PWM_BITS    (2),
        .BLINK_LOG2  (1)
    ) dut (
        .clk            (clk),
        .clear_n        (clear_n),
        .load           (load),
        .load_data      (load_data),
        .load_dp        (load_dp),
        .load_blank     (load_blank),
        .load_blink     (load_blink),
        .brightness     (brightness),
        .update_pending (update_pending),
        .frame_strobe   (frame_strobe),
        .sseg           (sseg),
        .an             (an)
    );

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [7:0] sseg;
        logic [7:0] an;
        logic       strobe;
        logic       pend;
    } exp_t;

    exp_t q[$];

    // Reference model state: m_n counts scan cycles since reset release.
    int unsigned m_n;
    logic [15:0] m_data, m_sdata;
    logic [3:0]  m_dp, m_sdp, m_blank, m_sblank, m_blink, m_sblink;
    logic        m_pend;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_data = '0; m_sdata = '0;
        m_dp = '0; m_sdp = '0;
        m_blank = '1; m_sblank = '1;
        m_blink = '0; m_sblink = '0;
        m_pend = 1'b0;
        q.delete();
    endtask

    function automatic void disp(input int unsigned n, output logic [7:0] s, output logic [7:0] a);
        int unsigned d;
        int unsigned slot;
        logic [3:0]  nib;
        logic        dk;
        d    = (n / 16) % 4;
        slot = n % 16;
        nib  = 4'((m_data >> (4 * d)) & 16'hF);
        dk   = m_blank[d] | (m_blink[d] & (((n / 128) % 2) == 1));
        s = 8'hFF;
        a = 8'hFF;
        if (!dk) begin
            s = seg_tab[nib];
            if (m_dp[d]) s[7] = 1'b0;
            if ((slot / 4) <= int'(brightness)) a[d] = 1'b0;
        end
    endfunction

    // Scoreboard producer: on each counting edge predict the registered outputs.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clear_n);
            if (!clear_n) begin
                model_reset();
            end else begin
                exp_t e;
                logic bnd;
                disp(m_n, e.sseg, e.an);
                bnd = ((m_n % 64) == 63);
                if (load) begin
                    m_sdata = load_data; m_sdp = load_dp;
                    m_sblank = load_blank; m_sblink = load_blink;
                    if (bnd) begin
                        m_data = load_data; m_dp = load_dp;
                        m_blank = load_blank; m_blink = load_blink;
                        m_pend = 1'b0;
                    end else begin
                        m_pend = 1'b1;
                    end
                end else if (bnd && m_pend) begin
                    m_data = m_sdata; m_dp = m_sdp;
                    m_blank = m_sblank; m_blink = m_sblink;
                    m_pend = 1'b0;
                end
                m_n = m_n + 1;
                e.strobe = ((m_n % 64) == 63);
                e.pend   = m_pend;
                q.push_back(e);
            end
        end
    end

    // Scoreboard consumer on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                chk("rst_sseg", sseg, 8'hFF);
                chk("rst_an", an, 8'hFF);
                chk("rst_strobe", {7'd0, frame_strobe}, 8'd0);
                chk("rst_pend", {7'd0, update_pending}, 8'd0);
            end else if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_sseg", sseg, e.sseg);
                chk("sb_an", an, e.an);
                chk("sb_strobe", {7'd0, frame_strobe}, {7'd0, e.strobe});
                chk("sb_pend", {7'd0, update_pending}, {7'd0, e.pend});
            end
        end
    end

    task automatic wait_state(input int unsigned target);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (((m_n % 64) != target) && (guard < 200));
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_state got=%0d want=%0d", m_n % 64, target);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic [3:0] bk);
        load_data = d; load_dp = dp; load_blank = bl; load_blink = bk;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [1:0]  br;
        logic [7:0]  exp_seg0;
        logic [7:0]  exp_an0;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   cnt;
        int   cnt_fe;
        int   cnt_f7;
        logic dk [8];
        logic [7:0] an_exp [4];
        logic [7:0] seg_exp [4];

        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 2'd3, 8'h99, 8'hFE};
        vecs[1] = '{16'hABCD, 4'b0001, 4'b0000, 2'd3, 8'h21, 8'hFE};
        vecs[2] = '{16'h00F8, 4'b0000, 4'b0001, 2'd3, 8'hFF, 8'hFF};
        vecs[3] = '{16'h5670, 4'b0000, 4'b0000, 2'd0, 8'hC0, 8'hFE};
        vecs[4] = '{16'hE00E, 4'b0001, 4'b0000, 2'd1, 8'h06, 8'hFE};
        an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        seg_exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

        repeat (3) @(posedge clk);
        #1 clear_n = 1'b1;

        // No load: dark display, one strobe per 64 cycles.
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (frame_strobe) cnt++;
        end
        chk("strobe_count", 8'(cnt), 8'd4);

        // Boundary load of 0x1234: digits scan right to left, 16 cycles each.
        brightness = 2'd3;
        wait_state(63);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        chk("bnd_load_pend", {7'd0, update_pending}, 8'd0);
        for (int k = 0; k < 4; k++) begin
            wait_state(16 * k + 1);
            chk("scan_an", an, an_exp[k]);
            chk("scan_sseg", sseg, seg_exp[k]);
        end

        // Table-driven boundary loads; digit 0 checked on the first output of the frame.
        for (int v = 0; v < 5; v++) begin
            brightness = vecs[v].br;
            wait_state(63);
            do_load(vecs[v].data, vecs[v].dp, vecs[v].blank, 4'b0000);
            @(posedge clk);
            #1;
            chk("vec_seg0", sseg, vecs[v].exp_seg0);
            chk("vec_an0", an, vecs[v].exp_an0);
            wait_state(40);
        end

        // PWM at brightness 0: 4 of 16 cycles lit per digit.
        brightness = 2'd0;
        wait_state(0);
        cnt_fe = 0;
        cnt_f7 = 0;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (an == 8'hFE) cnt_fe++;
            if (an == 8'hF7) cnt_f7++;
            if (an == 8'hFF) cnt++;
        end
        chk("pwm_d0_low", 8'(cnt_fe), 8'd4);
        chk("pwm_d3_low", 8'(cnt_f7), 8'd4);
        chk("pwm_dark", 8'(cnt), 8'd48);

        // Mid-frame loads: last one wins, applied at the boundary.
        brightness = 2'd3;
        wait_state(20);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        chk("mid_pend_set", {7'd0, update_pending}, 8'd1);
        wait_state(40);
        do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0000);
        wait_state(63);
        chk("mid_pend_hold", {7'd0, update_pending}, 8'd1);
        @(posedge clk);
        #1;
        chk("mid_pend_clr", {7'd0, update_pending}, 8'd0);
        @(posedge clk);
        #1;
        chk("mid_seg_d", sseg, 8'hA1);
        chk("mid_an_d", an, 8'hFE);

        // Blink on digit 0, dp on digit 1.
        wait_state(63);
        do_load(16'h1234, 4'b0010, 4'b0000, 4'b0001);
        cnt = 0;
        for (int f = 0; f < 8; f++) begin
            @(posedge clk);
            #1;
            dk[f] = (sseg == 8'hFF) && (an == 8'hFF);
            if (dk[f]) cnt++;
            if (f == 0) begin
                wait_state(17);
                chk("dp_digit1", {7'd0, sseg[7]}, 8'd0);
            end
            wait_state(0);
        end
        chk("blink_dark_frames", 8'(cnt), 8'd4);
        cnt = 0;
        for (int f = 0; f < 6; f++) begin
            if (dk[f] == dk[f + 2]) cnt++;
        end
        chk("blink_period", 8'(cnt), 8'd0);

        // Reset mid-slot with a pending load.
        wait_state(5);
        do_load(16'h4321, 4'b0000, 4'b0000, 4'b0000);
        chk("pre_rst_pend", {7'd0, update_pending}, 8'd1);
        #2 clear_n = 1'b0;
        #1;
        chk("rst_now_sseg", sseg, 8'hFF);
        chk("rst_now_an", an, 8'hFF);
        chk("rst_now_pend", {7'd0, update_pending}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 clear_n = 1'b1;
        wait_state(63);
        wait_state(63);
        chk("post_rst_pend", {7'd0, update_pending}, 8'd0);
        chk("post_rst_an", an, 8'hFF);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
